// File: rtl/uart_frame_loader.sv
// uart_frame_loader: turns a UART byte stream into framebuffer writes.
// Packets start with 0xA5 followed by a command byte:
//   0x01 <colour>      fill the whole frame with one colour
//   0x02 <px>.. <0x8x> stream packed pixel pairs from the write pointer
//   0x03 <b0><b1><b2>  set the write pointer to {b0[2:0], b1, b2}
// Each finished or rejected command queues a one-byte ACK/NAK for the
// UART transmitter.
module uart_frame_loader #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_we,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int                MAX        = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(MAX - 1);
  localparam logic [7:0]        SYNC       = 8'hA5;
  localparam logic [7:0]        CMD_FILL   = 8'h01;
  localparam logic [7:0]        CMD_STREAM = 8'h02;
  localparam logic [7:0]        CMD_POS    = 8'h03;
  localparam logic [7:0]        ACK        = 8'h06;
  localparam logic [7:0]        NAK        = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_FILL_COLOR,
    S_POS0,
    S_POS1,
    S_POS2,
    S_STREAM,
    S_WR_LO,
    S_WR_HI,
    S_FILL
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [2:0]         pos_b0;
  logic [7:0]         pos_b1;
  logic [PIX_W-1:0]   hi_pix;

  logic               pend_valid;
  logic [7:0]         pend_data;

  logic               ans_req;
  logic [7:0]         ans_code;
  logic               rx_drop;

  // Position candidate is assembled from the two stored bytes and the byte
  // arriving now, so it can be range-checked in the same cycle.
  logic [18:0]        cand;
  logic               cand_ok;
  assign cand    = {pos_b0, pos_b1, rx_data};
  assign cand_ok = (32'(cand) < 32'(MAX));

  // Pointer advance with wrap from the last pixel back to the first.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Decode which cycles produce an answer byte and which drop a received byte.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    ans_req  = 1'b0;
    ans_code = ACK;
    rx_drop  = 1'b0;
    if (rx_done) begin
      case (state)
        S_CMD: begin
          if (rx_data != CMD_FILL && rx_data != CMD_STREAM && rx_data != CMD_POS) begin
            ans_req  = 1'b1;
            ans_code = NAK;
          end
        end
        S_POS2: begin
          ans_req  = 1'b1;
          ans_code = cand_ok ? ACK : NAK;
        end
        S_STREAM: begin
          if (rx_data[7]) ans_req = 1'b1;
        end
        S_WR_LO, S_WR_HI, S_FILL: rx_drop = 1'b1;
        default: ;
      endcase
    end
    if (state == S_FILL && ram_addr == LAST) ans_req = 1'b1;
  end

  // Command parser and framebuffer write sequencer.
  always_ff @(posedge clk) begin
    // NOTE: state lives in flops, so every assignment here is non-blocking.
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      pos_b0     <= '0;
      pos_b1     <= '0;
      hi_pix     <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_done && rx_data == SYNC) state <= S_CMD;
        end
        S_CMD: begin
          if (rx_done) begin
            case (rx_data)
              CMD_FILL:   state <= S_FILL_COLOR;
              CMD_STREAM: state <= S_STREAM;
              CMD_POS:    state <= S_POS0;
              default:    state <= S_IDLE;
            endcase
          end
        end
        S_FILL_COLOR: begin
          // The colour stays on ram_data for the whole fill.
          if (rx_done) begin
            ram_addr   <= '0;
            ram_data   <= rx_data[PIX_W-1:0];
            ram_we     <= 1'b1;
            frame_done <= (LAST == '0);
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (ram_addr == LAST) begin
            ptr   <= '0;
            state <= S_IDLE;
          end else begin
            ram_addr   <= ram_addr + 1'b1;
            ram_we     <= 1'b1;
            frame_done <= (ram_addr == LAST - 1'b1);
          end
        end
        S_POS0: begin
          if (rx_done) begin
            pos_b0 <= rx_data[2:0];
            state  <= S_POS1;
          end
        end
        S_POS1: begin
          if (rx_done) begin
            pos_b1 <= rx_data;
            state  <= S_POS2;
          end
        end
        S_POS2: begin
          if (rx_done) begin
            if (cand_ok) ptr <= ADDR_W'(cand);
            state <= S_IDLE;
          end
        end
        S_STREAM: begin
          if (rx_done) begin
            if (rx_data[7]) begin
              state <= S_IDLE;
            end else begin
              ram_addr   <= ptr;
              ram_data   <= rx_data[PIX_W-1:0];
              ram_we     <= 1'b1;
              frame_done <= (ptr == LAST);
              hi_pix     <= rx_data[4 +: PIX_W];
              ptr        <= ptr_inc(ptr);
              state      <= S_WR_LO;
            end
          end
        end
        S_WR_LO: begin
          // Low pixel is on the bus now; queue the high pixel for next cycle.
          ram_addr   <= ptr;
          ram_data   <= hi_pix;
          ram_we     <= 1'b1;
          frame_done <= (ptr == LAST);
          ptr        <= ptr_inc(ptr);
          state      <= S_WR_HI;
        end
        S_WR_HI: state <= S_STREAM;
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry answer buffer towards the transmitter, plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start   <= 1'b0;
      tx_data    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overrun    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (pend_valid && !tx_busy) begin
        tx_start   <= 1'b1;
        tx_data    <= pend_data;
        pend_valid <= 1'b0;
      end
      // A new answer fits if the buffer is empty or is being drained this cycle.
      if (ans_req) begin
        if (!pend_valid || !tx_busy) begin
          pend_valid <= 1'b1;
          pend_data  <= ans_code;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (rx_drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Testbench for uart_frame_loader on a reduced 40x30 frame (MAX = 1200).
module tb_uart_frame_loader;

  localparam int         WIDTH  = 40;
  localparam int         HEIGHT = 30;
  localparam int         ADDR_W = 19;
  localparam int         PIX_W  = 3;
  localparam int         MAX    = WIDTH * HEIGHT;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic              tx_busy = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_we;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              frame_done;
  logic              overrun;

  uart_frame_loader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_done(rx_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit fd;
    int cyc;
  } wr_t;

  wr_t got_wr[$];
  wr_t exp_wr[$];
  int  got_tx[$];
  int  exp_tx[$];

  int cyc = 0;
  int stray_fd = 0;
  int last_rx_cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Reference model state: write pointer and the bytes of the open packet.
  int         m_ptr = 0;
  logic [7:0] m_pkt[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ram_we)
      got_wr.push_back('{addr: int'(ram_addr), data: int'(ram_data), fd: frame_done, cyc: cyc});
    else if (frame_done)
      stray_fd++;
    if (tx_start) got_tx.push_back(int'(tx_data));
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int tx_at(input int i);
    return (i < got_tx.size()) ? got_tx[i] : -1;
  endfunction

  function automatic int wr_addr(input int i);
    return (i < got_wr.size()) ? got_wr[i].addr : -1;
  endfunction

  function automatic int wr_data(input int i);
    return (i < got_wr.size()) ? got_wr[i].data : -1;
  endfunction

  function automatic int wr_fd(input int i);
    return (i < got_wr.size()) ? int'(got_wr[i].fd) : -1;
  endfunction

  task automatic flush();
    got_wr.delete();
    exp_wr.delete();
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_done = 1'b0;
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_pkt.delete();
    stray_fd = 0;
    flush();
  endtask

  // One-cycle rx_done strobe; returns on the falling edge right after the
  // DUT has sampled the byte.
  task automatic send_raw(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b);
    repeat (4) @(negedge clk);
  endtask

  // Packet-level reference: interprets the buffered packet once it is
  // long enough and appends the writes and answers it implies.
  task automatic model_byte(input logic [7:0] b, output bit fill);
    logic [7:0] cmd;
    logic [7:0] b0;
    int cand;
    fill = 1'b0;
    if (m_pkt.size() == 0) begin
      if (b == 8'hA5) m_pkt.push_back(b);
      return;
    end
    m_pkt.push_back(b);
    cmd = m_pkt[1];
    if (m_pkt.size() == 2) begin
      if (!(cmd inside {8'h01, 8'h02, 8'h03})) begin
        exp_tx.push_back(int'(NAK));
        m_pkt.delete();
      end
      return;
    end
    case (cmd)
      8'h03: begin
        if (m_pkt.size() == 5) begin
          b0 = m_pkt[2];
          cand = int'(b0[2:0]) * 65536 + int'(m_pkt[3]) * 256 + int'(m_pkt[4]);
          if (cand < MAX) begin
            m_ptr = cand;
            exp_tx.push_back(int'(ACK));
          end else begin
            exp_tx.push_back(int'(NAK));
          end
          m_pkt.delete();
        end
      end
      8'h01: begin
        for (int a = 0; a < MAX; a++)
          exp_wr.push_back('{addr: a, data: int'(b[2:0]), fd: (a == MAX - 1), cyc: 0});
        m_ptr = 0;
        exp_tx.push_back(int'(ACK));
        m_pkt.delete();
        fill = 1'b1;
      end
      default: begin
        if (b[7]) begin
          exp_tx.push_back(int'(ACK));
          m_pkt.delete();
        end else begin
          exp_wr.push_back('{addr: m_ptr, data: int'(b[2:0]), fd: (m_ptr == MAX - 1), cyc: 0});
          m_ptr = (m_ptr + 1) % MAX;
          exp_wr.push_back('{addr: m_ptr, data: int'(b[6:4]), fd: (m_ptr == MAX - 1), cyc: 0});
          m_ptr = (m_ptr + 1) % MAX;
          void'(m_pkt.pop_back());
        end
      end
    endcase
  endtask

  task automatic rand_byte(input logic [7:0] b);
    bit fill;
    model_byte(b, fill);
    send_raw(b);
    repeat (fill ? MAX + 8 : 4) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    int bad;
    bad = -1;
    check({tag, " write count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      if (got_wr[i].addr != exp_wr[i].addr || got_wr[i].data != exp_wr[i].data ||
          got_wr[i].fd != exp_wr[i].fd) begin
        bad = i;
        break;
      end
    end
    if (bad >= 0)
      $display("[TB] %s write %0d: got (%0d,%0d,fd=%0d) expected (%0d,%0d,fd=%0d)", tag, bad,
               got_wr[bad].addr, got_wr[bad].data, got_wr[bad].fd,
               exp_wr[bad].addr, exp_wr[bad].data, exp_wr[bad].fd);
    check({tag, " first bad write"}, bad, -1);
  endtask

  task automatic compare_tx(input string tag);
    int bad;
    bad = -1;
    check({tag, " answer count"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) begin
      if (got_tx[i] != exp_tx[i]) begin
        bad = i;
        break;
      end
    end
    check({tag, " first bad answer"}, bad, -1);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] ans;
    int         ptr;
  } pos_vec_t;

  pos_vec_t pv[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fill_rx;
    int bad;
    int found;
    int fills;
    int kind;
    int cand;
    int npx;
    logic [7:0] b;

    // Position vectors; ptr is where the following probe stream lands, which
    // for a NAK is the pointer left behind by the previous probe.
    pv[0] = '{8'h00, 8'h01, 8'h2C, ACK, 300};
    pv[1] = '{8'h07, 8'hFF, 8'hFF, NAK, 302};
    pv[2] = '{8'h00, 8'h04, 8'hAF, ACK, 1199};
    pv[3] = '{8'h00, 8'h04, 8'hB0, NAK, 1};
    pv[4] = '{8'hF8, 8'h00, 8'h07, ACK, 7};
    pv[5] = '{8'h00, 8'h00, 8'h00, ACK, 0};
    pv[6] = '{8'h01, 8'h00, 8'h00, NAK, 2};

    // Reset values
    do_reset();
    check("reset ram_we", ram_we, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_data", ram_data, 0);
    check("reset tx_start", tx_start, 0);
    check("reset tx_data", tx_data, 0);
    check("reset frame_done", frame_done, 0);
    check("reset overrun", overrun, 0);

    // Table-driven position commands, each followed by a probe stream.
    for (int i = 0; i < 7; i++) begin
      flush();
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(pv[i].b0);
      send_byte(pv[i].b1);
      send_byte(pv[i].b2);
      check($sformatf("pos%0d answer", i), tx_at(0), pv[i].ans);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h70);
      send_byte(8'h80);
      check($sformatf("pos%0d probe lo addr", i), wr_addr(0), pv[i].ptr);
      check($sformatf("pos%0d probe lo data", i), wr_data(0), 0);
      check($sformatf("pos%0d probe hi addr", i), wr_addr(1), (pv[i].ptr + 1) % MAX);
      check($sformatf("pos%0d probe hi data", i), wr_data(1), 7);
      check($sformatf("pos%0d answers", i), got_tx.size(), 2);
    end

    // Stream write timing after position 300.
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h2C);
    send_byte(8'hA5);
    send_byte(8'h02);
    flush();
    send_raw(8'h21);
    check("stream N+1 we", ram_we, 1);
    check("stream N+1 addr", ram_addr, 300);
    check("stream N+1 data", ram_data, 1);
    @(negedge clk);
    check("stream N+2 we", ram_we, 1);
    check("stream N+2 addr", ram_addr, 301);
    check("stream N+2 data", ram_data, 2);
    @(negedge clk);
    check("stream N+3 we", ram_we, 0);
    repeat (2) @(negedge clk);
    send_byte(8'h80);
    check("stream writes", got_wr.size(), 2);
    check("stream answer", tx_at(0), ACK);

    // Wrap at the last pixel.
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hAF);
    flush();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h53);
    send_byte(8'h80);
    check("wrap w0 addr", wr_addr(0), MAX - 1);
    check("wrap w0 data", wr_data(0), 3);
    check("wrap w0 frame_done", wr_fd(0), 1);
    check("wrap w1 addr", wr_addr(1), 0);
    check("wrap w1 data", wr_data(1), 5);
    check("wrap w1 frame_done", wr_fd(1), 0);
    check("wrap stray frame_done", stray_fd, 0);

    // Fill with a byte injected mid-fill.
    flush();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_raw(8'h04);
    fill_rx = last_rx_cyc;
    repeat (100) @(negedge clk);
    check("fill overrun before inject", overrun, 0);
    send_raw(8'hA5);
    check("fill overrun after inject", overrun, 1);
    repeat (MAX + 10) @(negedge clk);
    check("fill write count", got_wr.size(), MAX);
    bad = -1;
    for (int i = 0; i < got_wr.size(); i++) begin
      if (got_wr[i].addr != i || got_wr[i].data != 4 || got_wr[i].cyc != fill_rx + 1 + i ||
          got_wr[i].fd != (i == MAX - 1)) begin
        bad = i;
        break;
      end
    end
    check("fill first bad write", bad, -1);
    check("fill answer", tx_at(0), ACK);
    check("fill answer count", got_tx.size(), 1);
    flush();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h70);
    send_byte(8'h80);
    check("fill ptr reset", wr_addr(0), 0);
    check("fill overrun sticky", overrun, 1);

    // Answer backpressure.
    do_reset();
    tx_busy = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h7E);
    check("bp no tx while busy", got_tx.size(), 0);
    check("bp overrun after first", overrun, 0);
    send_byte(8'hA5);
    send_byte(8'h7F);
    check("bp overrun after second", overrun, 1);
    repeat (10) @(negedge clk);
    check("bp still no tx", got_tx.size(), 0);
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("bp tx count", got_tx.size(), 1);
    check("bp tx data", tx_at(0), NAK);

    // Reset in the middle of a fill.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_raw(8'h02);
    found = 0;
    for (int k = 0; k < MAX + 10; k++) begin
      if (ram_we && ram_addr == 1000) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rstfill reached 1000", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstfill ram_we", ram_we, 0);
    check("rstfill ram_addr", ram_addr, 0);
    rst = 1'b0;
    flush();
    repeat (20) @(negedge clk);
    check("rstfill no writes", got_wr.size(), 0);
    check("rstfill no answer", got_tx.size(), 0);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    check("rstfill pos answer", tx_at(0), ACK);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h70);
    send_byte(8'h80);
    check("rstfill pos ptr", wr_addr(0), 5);

    // Randomized packets against the reference model.
    do_reset();
    fills = 0;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        rand_byte(b);
      end else if (kind <= 2) begin
        rand_byte(8'hA5);
        rand_byte(8'($urandom_range(4, 255)));
      end else if (kind <= 7) begin
        if ($urandom_range(0, 1) == 1) cand = $urandom_range(0, MAX - 1);
        else cand = $urandom_range(0, 524287);
        rand_byte(8'hA5);
        rand_byte(8'h03);
        rand_byte((8'($urandom) & 8'hF8) | 8'(cand >> 16));
        rand_byte(8'(cand >> 8));
        rand_byte(8'(cand));
      end else if (kind <= 18 || fills >= 2) begin
        rand_byte(8'hA5);
        rand_byte(8'h02);
        npx = $urandom_range(0, 6);
        for (int k = 0; k < npx; k++) rand_byte(8'($urandom) & 8'h7F);
        rand_byte(8'($urandom) | 8'h80);
      end else begin
        fills++;
        rand_byte(8'hA5);
        rand_byte(8'h01);
        rand_byte(8'($urandom));
      end
    end
    repeat (10) @(negedge clk);
    compare_writes("rand");
    compare_tx("rand");
    check("rand overrun", overrun, 0);
    check("rand stray frame_done", stray_fd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
